// File: rtl/sparse_sel_pkg.sv
// rtl/sparse_sel_pkg.sv - shared sizes, byte type and popcount for the sparse input selector
package sparse_sel_pkg;
   localparam int MEM_SIZE         = 128;
   localparam int BUS_SIZE         = 16;
   localparam int PREFIX_SUM_SIZE  = 32;
   localparam int WR_DAT_CYC_NUM   = MEM_SIZE / BUS_SIZE;
   localparam int RD_SPARSEMAP_NUM = MEM_SIZE / PREFIX_SUM_SIZE;
   localparam int WR_CNT_W         = $clog2(WR_DAT_CYC_NUM);
   localparam int SEG_W            = $clog2(RD_SPARSEMAP_NUM);
   localparam int PICK_W           = $clog2(PREFIX_SUM_SIZE);
   localparam int ADDR_W           = $clog2(MEM_SIZE);
   localparam int PTR_W            = ADDR_W + 1;

   typedef logic [7:0] byte_t;

   function automatic logic [PTR_W-1:0] popcount(input logic [MEM_SIZE-1:0] v);
      logic [PTR_W-1:0] n;
      n = '0;
      for (int i = 0; i < MEM_SIZE; i++) n = n + PTR_W'(v[i]);
      return n;
   endfunction
endpackage

// File: rtl/sparse_input_selector_chunk.sv
// rtl/sparse_input_selector_chunk.sv - double-buffered compressed chunk store (sparsemap + packed bytes)
module sparse_data_chunk
   import sparse_sel_pkg::*;
(
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [BUS_SIZE-1:0]        sparsemap_i,
   input  logic [BUS_SIZE*8-1:0]      nonzero_data_i,
   input  logic                       wr_valid_i,
   input  logic [WR_CNT_W-1:0]        wr_count_i,
   input  logic                       wr_sel_i,
   input  logic                       rd_sel_i,
   input  logic [SEG_W-1:0]           seg_addr_i,
   input  logic [ADDR_W-1:0]          rd_addr_i,
   output logic [PREFIX_SUM_SIZE-1:0] seg_o,
   output logic [7:0]                 rd_data_o
);
   logic [MEM_SIZE-1:0] smap [2];
   logic [PTR_W-1:0]    wr_ptr [2];
   byte_t               data_mem [2][MEM_SIZE];
   logic [PTR_W-1:0]    wr_base;
   logic [PTR_W-1:0]    wr_num;
   logic [MEM_SIZE-1:0] rd_mask;
   logic [ADDR_W-1:0]   rd_idx;

   assign wr_base = (wr_count_i == '0) ? '0 : wr_ptr[wr_sel_i];
   assign wr_num  = popcount({{(MEM_SIZE-BUS_SIZE){1'b0}}, sparsemap_i});

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         smap[0]   <= '0;
         smap[1]   <= '0;
         wr_ptr[0] <= '0;
         wr_ptr[1] <= '0;
      end else if (wr_valid_i) begin
         smap[wr_sel_i][int'(wr_count_i)*BUS_SIZE +: BUS_SIZE] <= sparsemap_i;
         wr_ptr[wr_sel_i] <= wr_base + wr_num;
      end
   end

   // Only the first popcount lanes carry real bytes; they land contiguously at the bank pointer.
   always_ff @(posedge clk_i) begin
      if (wr_valid_i) begin
         for (int k = 0; k < BUS_SIZE; k++) begin
            if (PTR_W'(k) < wr_num)
               data_mem[wr_sel_i][ADDR_W'(wr_base + PTR_W'(k))] <= nonzero_data_i[k*8 +: 8];
         end
      end
   end

   assign seg_o     = smap[rd_sel_i][int'(seg_addr_i)*PREFIX_SUM_SIZE +: PREFIX_SUM_SIZE];
   assign rd_mask   = (MEM_SIZE'(1) << rd_addr_i) - MEM_SIZE'(1);
   assign rd_idx    = ADDR_W'(popcount(smap[rd_sel_i] & rd_mask));
   assign rd_data_o = data_mem[rd_sel_i][rd_idx];
endmodule

// File: rtl/sparse_input_selector.sv
// rtl/sparse_input_selector.sv - zero-skipping (ifm, filter) operand pair selector for the MAC lane
module sparse_input_selector
   import sparse_sel_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [BUS_SIZE-1:0]   ifm_sparsemap_i,
   input  logic [BUS_SIZE*8-1:0] ifm_nonzero_data_i,
   input  logic                  ifm_wr_valid_i,
   input  logic [WR_CNT_W-1:0]   ifm_wr_count_i,
   input  logic                  ifm_wr_sel_i,
   input  logic                  ifm_rd_sel_i,
   input  logic [BUS_SIZE-1:0]   filter_sparsemap_i,
   input  logic [BUS_SIZE*8-1:0] filter_nonzero_data_i,
   input  logic                  filter_wr_valid_i,
   input  logic [WR_CNT_W-1:0]   filter_wr_count_i,
   input  logic                  filter_wr_sel_i,
   input  logic                  filter_rd_sel_i,
   input  logic                  run_valid_i,
   input  logic                  chunk_start_i,
   input  logic [SEG_W-1:0]      rd_sparsemap_num_i,
   output logic [7:0]            ifm_data_o,
   output logic [7:0]            filter_data_o,
   output logic                  data_valid_o,
   output logic                  chunk_end_o
);
   logic [SEG_W-1:0]           seg_addr;
   logic [PREFIX_SUM_SIZE-1:0] consumed;
   logic [PREFIX_SUM_SIZE-1:0] remaining;
   logic [PREFIX_SUM_SIZE-1:0] ifm_seg;
   logic [PREFIX_SUM_SIZE-1:0] filter_seg;
   logic                       run_valid_r;
   logic                       active;
   logic                       has_pick;
   logic                       last;
   logic                       chunk_end;
   logic [PICK_W-1:0]          pick;
   logic [ADDR_W-1:0]          abs_addr;
   logic [7:0]                 ifm_byte;
   logic [7:0]                 filter_byte;

   sparse_data_chunk u_ifm (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .sparsemap_i    (ifm_sparsemap_i),
      .nonzero_data_i (ifm_nonzero_data_i),
      .wr_valid_i     (ifm_wr_valid_i),
      .wr_count_i     (ifm_wr_count_i),
      .wr_sel_i       (ifm_wr_sel_i),
      .rd_sel_i       (ifm_rd_sel_i),
      .seg_addr_i     (seg_addr),
      .rd_addr_i      (abs_addr),
      .seg_o          (ifm_seg),
      .rd_data_o      (ifm_byte)
   );

   sparse_data_chunk u_filter (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .sparsemap_i    (filter_sparsemap_i),
      .nonzero_data_i (filter_nonzero_data_i),
      .wr_valid_i     (filter_wr_valid_i),
      .wr_count_i     (filter_wr_count_i),
      .wr_sel_i       (filter_wr_sel_i),
      .rd_sel_i       (filter_rd_sel_i),
      .seg_addr_i     (seg_addr),
      .rd_addr_i      (abs_addr),
      .seg_o          (filter_seg),
      .rd_data_o      (filter_byte)
   );

   assign remaining = ifm_seg & filter_seg & ~consumed;
   assign active    = run_valid_i && run_valid_r;
   assign has_pick  = active && (remaining != '0);
   // At most one bit left means this cycle finishes the segment (also true for an empty one).
   assign last      = active && ((remaining & (remaining - 1'b1)) == '0);
   assign chunk_end = ((seg_addr == rd_sparsemap_num_i) && last) || !run_valid_r;
   assign chunk_end_o = chunk_end;
   assign abs_addr  = ADDR_W'(int'(seg_addr) * PREFIX_SUM_SIZE + int'(pick));

   always_comb begin
      pick = '0;
      for (int i = PREFIX_SUM_SIZE - 1; i >= 0; i--)
         if (remaining[i]) pick = PICK_W'(i);
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         seg_addr    <= '0;
         consumed    <= '0;
         run_valid_r <= 1'b1;
      end else if (chunk_start_i) begin
         seg_addr    <= '0;
         consumed    <= '0;
         run_valid_r <= 1'b1;
      end else begin
         if (last) begin
            consumed <= '0;
            seg_addr <= seg_addr + 1'b1;
         end else if (has_pick) begin
            consumed[pick] <= 1'b1;
         end
         if (chunk_end) run_valid_r <= 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ifm_data_o    <= '0;
         filter_data_o <= '0;
         data_valid_o  <= 1'b0;
      end else begin
         data_valid_o <= has_pick;
         if (has_pick) begin
            ifm_data_o    <= ifm_byte;
            filter_data_o <= filter_byte;
         end
      end
   end
endmodule

// File: tb/tb_sparse_input_selector.sv
// tb/tb_sparse_input_selector.sv - self-checking bench for sparse_input_selector
module tb_sparse_input_selector;
   import sparse_sel_pkg::*;

   logic                  clk_i = 1'b0;
   logic                  rst_i;
   logic [BUS_SIZE-1:0]   ifm_sparsemap_i, filter_sparsemap_i;
   logic [BUS_SIZE*8-1:0] ifm_nonzero_data_i, filter_nonzero_data_i;
   logic                  ifm_wr_valid_i, filter_wr_valid_i;
   logic [WR_CNT_W-1:0]   ifm_wr_count_i, filter_wr_count_i;
   logic                  ifm_wr_sel_i, filter_wr_sel_i;
   logic                  ifm_rd_sel_i, filter_rd_sel_i;
   logic                  run_valid_i, chunk_start_i;
   logic [SEG_W-1:0]      rd_sparsemap_num_i;
   logic [7:0]            ifm_data_o, filter_data_o;
   logic                  data_valid_o, chunk_end_o;

   always #5 clk_i = ~clk_i;

   sparse_input_selector dut (
      .clk_i                 (clk_i),
      .rst_i                 (rst_i),
      .ifm_sparsemap_i       (ifm_sparsemap_i),
      .ifm_nonzero_data_i    (ifm_nonzero_data_i),
      .ifm_wr_valid_i        (ifm_wr_valid_i),
      .ifm_wr_count_i        (ifm_wr_count_i),
      .ifm_wr_sel_i          (ifm_wr_sel_i),
      .ifm_rd_sel_i          (ifm_rd_sel_i),
      .filter_sparsemap_i    (filter_sparsemap_i),
      .filter_nonzero_data_i (filter_nonzero_data_i),
      .filter_wr_valid_i     (filter_wr_valid_i),
      .filter_wr_count_i     (filter_wr_count_i),
      .filter_wr_sel_i       (filter_wr_sel_i),
      .filter_rd_sel_i       (filter_rd_sel_i),
      .run_valid_i           (run_valid_i),
      .chunk_start_i         (chunk_start_i),
      .rd_sparsemap_num_i    (rd_sparsemap_num_i),
      .ifm_data_o            (ifm_data_o),
      .filter_data_o         (filter_data_o),
      .data_valid_o          (data_valid_o),
      .chunk_end_o           (chunk_end_o)
   );

   // Channel-level reference: per bank, which channels are non-zero and their byte values.
   logic [MEM_SIZE-1:0] m_imap [2];
   logic [MEM_SIZE-1:0] m_fmap [2];
   logic [7:0]          m_ival [2][MEM_SIZE];
   logic [7:0]          m_fval [2][MEM_SIZE];
   logic [15:0]         exp_q[$];
   logic [15:0]         got_q[$];
   logic                vtrace [0:511];
   int                  n_checks = 0;
   int                  n_errors = 0;
   int                  last_cycles;
   int                  got_at_end;
   int                  exp_cycles;

   typedef struct {
      logic [MEM_SIZE-1:0] imap;
      logic [MEM_SIZE-1:0] fmap;
      int                  num;
      int                  pairs;
      int                  cycles;
      bit                  empty_chk;
   } vec_t;
   vec_t tbl [6];

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_errors++;
         $display("FAIL %s: got %0d required %0d", name, act, req);
      end
   endtask

   task automatic write_bank(input int bank);
      for (int c = 0; c < WR_DAT_CYC_NUM; c++) begin
         logic [BUS_SIZE*8-1:0] id, fd;
         int ki, kf;
         id = '0; fd = '0; ki = 0; kf = 0;
         for (int i = 0; i < BUS_SIZE; i++) begin
            int ch;
            ch = c * BUS_SIZE + i;
            if (m_imap[bank][ch]) begin id[ki*8 +: 8] = m_ival[bank][ch]; ki++; end
            if (m_fmap[bank][ch]) begin fd[kf*8 +: 8] = m_fval[bank][ch]; kf++; end
         end
         ifm_sparsemap_i       = m_imap[bank][c*BUS_SIZE +: BUS_SIZE];
         filter_sparsemap_i    = m_fmap[bank][c*BUS_SIZE +: BUS_SIZE];
         ifm_nonzero_data_i    = id;
         filter_nonzero_data_i = fd;
         ifm_wr_count_i        = WR_CNT_W'(c);
         filter_wr_count_i     = WR_CNT_W'(c);
         ifm_wr_sel_i          = bank[0];
         filter_wr_sel_i       = bank[0];
         ifm_wr_valid_i        = 1'b1;
         filter_wr_valid_i     = 1'b1;
         @(posedge clk_i); #1;
      end
      ifm_wr_valid_i    = 1'b0;
      filter_wr_valid_i = 1'b0;
   endtask

   task automatic model_expect(input int bank, input int num, output int cycles);
      exp_q.delete();
      cycles = 0;
      for (int s = 0; s <= num; s++) begin
         int n;
         n = 0;
         for (int b = 0; b < PREFIX_SUM_SIZE; b++) begin
            int ch;
            ch = s * PREFIX_SUM_SIZE + b;
            if (m_imap[bank][ch] && m_fmap[bank][ch]) begin
               exp_q.push_back({m_ival[bank][ch], m_fval[bank][ch]});
               n++;
            end
         end
         cycles += (n == 0) ? 1 : n;
      end
   endtask

   task automatic start_scan(input int bank, input int num);
      ifm_rd_sel_i       = bank[0];
      filter_rd_sel_i    = bank[0];
      rd_sparsemap_num_i = SEG_W'(num);
      run_valid_i        = 1'b0;
      chunk_start_i      = 1'b1;
      @(posedge clk_i); #1;
      chunk_start_i      = 1'b0;
   endtask

   task automatic run_scan(input int stall_at, input int stall_len);
      int  cyc;
      bit  done;
      bit  hold_bad;
      cyc = 0; done = 0; hold_bad = 0; got_at_end = -1;
      got_q.delete();
      while (!done && cyc < 400) begin
         run_valid_i = !((cyc + 1 >= stall_at) && (cyc + 1 < stall_at + stall_len));
         @(negedge clk_i);
         cyc++;
         vtrace[cyc] = data_valid_o;
         if (data_valid_o) got_q.push_back({ifm_data_o, filter_data_o});
         if (chunk_end_o && run_valid_i) begin
            done = 1;
            got_at_end = got_q.size();
         end
         @(posedge clk_i); #1;
      end
      check("scan_reached_end", int'(done), 1);
      last_cycles = cyc;
      run_valid_i = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk_i);
         if (data_valid_o) got_q.push_back({ifm_data_o, filter_data_o});
         if (k > 1 && data_valid_o) hold_bad = 1;
         if (!chunk_end_o) hold_bad = 1;
         @(posedge clk_i); #1;
      end
      check("end_held_until_start", int'(hold_bad), 0);
      run_valid_i = 1'b0;
   endtask

   task automatic compare(input string name);
      int bad;
      bad = -1;
      check({name, "_pair_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         if (got_q[i] != exp_q[i]) begin
            bad = i;
            break;
         end
      end
      n_checks++;
      if (bad >= 0) begin
         n_errors++;
         $display("FAIL %s_pairs: index %0d got %h required %h", name, bad, got_q[bad], exp_q[bad]);
      end
   endtask

   task automatic fill_dense(input int bank);
      m_imap[bank] = ~'0;
      m_fmap[bank] = ~'0;
      for (int ch = 0; ch < MEM_SIZE; ch++) begin
         m_ival[bank][ch] = 8'(ch);
         m_fval[bank][ch] = 8'(128 + ch);
      end
   endtask

   task automatic fill_random(input int bank, input int di, input int df);
      for (int ch = 0; ch < MEM_SIZE; ch++) begin
         m_imap[bank][ch] = ($urandom_range(0, 99) < di);
         m_fmap[bank][ch] = ($urandom_range(0, 99) < df);
         m_ival[bank][ch] = 8'($urandom);
         m_fval[bank][ch] = 8'($urandom);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{imap: (128'd1 << 3) | (128'd1 << 5) | (128'd1 << 40),
                 fmap: (128'd1 << 5) | (128'd1 << 40) | (128'd1 << 100),
                 num: 3, pairs: 2, cycles: 4, empty_chk: 1'b0};
      tbl[1] = '{imap: '0, fmap: '0, num: 3, pairs: 0, cycles: 4, empty_chk: 1'b0};
      tbl[2] = '{imap: 128'hFFFF_FFFF, fmap: ~128'd0, num: 0, pairs: 32, cycles: 32, empty_chk: 1'b0};
      tbl[3] = '{imap: (128'd3 << 64) | 128'd3, fmap: (128'd3 << 64) | 128'd3,
                 num: 2, pairs: 4, cycles: 5, empty_chk: 1'b0};
      tbl[4] = '{imap: (128'd1 << 5) | (128'd1 << 10) | (128'd1 << 40) | (128'd1 << 70) | (128'd1 << 100),
                 fmap: (128'd1 << 5) | (128'd1 << 41) | (128'd1 << 71) | (128'd1 << 100),
                 num: 3, pairs: 2, cycles: 4, empty_chk: 1'b1};
      tbl[5] = '{imap: ~128'd0, fmap: (128'd1 << 31) | (128'd1 << 32) | (128'd1 << 127),
                 num: 1, pairs: 2, cycles: 2, empty_chk: 1'b0};

      rst_i = 1'b0;
      ifm_sparsemap_i = '0; filter_sparsemap_i = '0;
      ifm_nonzero_data_i = '0; filter_nonzero_data_i = '0;
      ifm_wr_valid_i = 1'b0; filter_wr_valid_i = 1'b0;
      ifm_wr_count_i = '0; filter_wr_count_i = '0;
      ifm_wr_sel_i = 1'b0; filter_wr_sel_i = 1'b0;
      ifm_rd_sel_i = 1'b0; filter_rd_sel_i = 1'b0;
      run_valid_i = 1'b0; chunk_start_i = 1'b0; rd_sparsemap_num_i = '0;
      repeat (3) @(posedge clk_i);
      #1;
      check("reset_data_valid", int'(data_valid_o), 0);
      check("reset_ifm_data", int'(ifm_data_o), 0);
      check("reset_filter_data", int'(filter_data_o), 0);
      check("reset_chunk_end", int'(chunk_end_o), 0);
      rst_i = 1'b1;
      @(posedge clk_i); #1;

      // Dense match: every channel pairs, end coincides with the pick of channel 127.
      fill_dense(0);
      write_bank(0);
      model_expect(0, 3, exp_cycles);
      start_scan(0, 3);
      run_scan(0, 0);
      compare("dense");
      check("dense_cycles", last_cycles, 128);
      check("dense_end_with_pick127", got_at_end, 127);

      for (int t = 0; t < 6; t++) begin
         m_imap[0] = tbl[t].imap;
         m_fmap[0] = tbl[t].fmap;
         for (int ch = 0; ch < MEM_SIZE; ch++) begin
            m_ival[0][ch] = 8'(ch * 3 + t);
            m_fval[0][ch] = 8'(255 - ch - t);
         end
         write_bank(0);
         model_expect(0, tbl[t].num, exp_cycles);
         start_scan(0, tbl[t].num);
         run_scan(0, 0);
         compare($sformatf("table%0d", t));
         check($sformatf("table%0d_pairs", t), got_q.size(), tbl[t].pairs);
         check($sformatf("table%0d_cycles", t), last_cycles, tbl[t].cycles);
         if (tbl[t].empty_chk) begin
            check("empty_seg1_no_valid", int'(vtrace[3]), 0);
            check("empty_seg2_no_valid", int'(vtrace[4]), 0);
         end
      end

      for (int r = 0; r < 6; r++) begin
         int bank, num;
         bank = $urandom_range(0, 1);
         num  = $urandom_range(0, 3);
         fill_random(bank, $urandom_range(5, 100), $urandom_range(5, 100));
         write_bank(bank);
         model_expect(bank, num, exp_cycles);
         start_scan(bank, num);
         run_scan(0, 0);
         compare($sformatf("random%0d", r));
         check($sformatf("random%0d_cycles", r), last_cycles, exp_cycles);
      end

      // Stall for 3 cycles mid-segment; sequence must resume intact.
      fill_random(0, 100, 50);
      write_bank(0);
      model_expect(0, 3, exp_cycles);
      start_scan(0, 3);
      run_scan(12, 3);
      compare("stall");
      check("stall_cycles", last_cycles, exp_cycles + 3);
      check("stall_no_valid_a", int'(vtrace[13]), 0);
      check("stall_no_valid_b", int'(vtrace[14]), 0);
      check("stall_no_valid_c", int'(vtrace[15]), 0);

      // Double buffer: write bank 1 while bank 0 is being scanned.
      fill_random(0, 100, 60);
      write_bank(0);
      fill_random(1, 70, 70);
      model_expect(0, 3, exp_cycles);
      start_scan(0, 3);
      fork
         run_scan(0, 0);
         write_bank(1);
      join
      compare("dbuf_bank0");
      model_expect(1, 3, exp_cycles);
      start_scan(1, 3);
      run_scan(0, 0);
      compare("dbuf_bank1");

      // Asynchronous reset mid-scan.
      fill_dense(0);
      write_bank(0);
      start_scan(0, 3);
      run_valid_i = 1'b1;
      repeat (20) begin
         @(posedge clk_i); #1;
      end
      check("pre_reset_valid", int'(data_valid_o), 1);
      #2;
      rst_i = 1'b0;
      #1;
      check("async_reset_valid", int'(data_valid_o), 0);
      check("async_reset_ifm", int'(ifm_data_o), 0);
      check("async_reset_filter", int'(filter_data_o), 0);
      run_valid_i = 1'b0;
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      start_scan(0, 3);
      run_scan(0, 0);
      check("reset_cleared_maps_pairs", got_q.size(), 0);
      check("reset_cleared_maps_cycles", last_cycles, 4);
      write_bank(0);
      model_expect(0, 3, exp_cycles);
      start_scan(0, 3);
      run_scan(0, 0);
      compare("after_reset");
      check("after_reset_cycles", last_cycles, 128);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
